// File: rtl/alu_mc.sv
// Multi-cycle MIPS ALU: 1-cycle logic/arith/shift ops, WIDTH-step shift-add multiply and restoring divide.
// Latency is 1 (single-cycle) or WIDTH+1 (mul/div) start-to-done; busy stalls the pipe. Divider gated by ALU_MC_DIVIDER_EN.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] hi,
    output logic             z,
    output logic             v,
    output logic             n,
    output logic             err
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t st;

    logic [CW-1:0]      cnt, cnt_nxt;
    logic [WIDTH-1:0]   wk_hi, wk_lo, mag;
    logic               neg_q;

    logic [WIDTH-1:0]   add_r, sub_r, s_y, mag_a, mag_b;
    logic [3:0]         tt;
    logic               s_v, s_err, s_hi_we, is_mul, multi, sgn;

    logic [WIDTH:0]     m_sum;
    logic [WIDTH-1:0]   nx_hi, nx_lo, f_y, f_hi;
    logic [2*WIDTH-1:0] prod;
    logic               f_v, f_err;

`ifdef ALU_MC_DIVIDER_EN
    logic               is_div, mode_div, b_zero, ovf, neg_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH:0]     d_rs, d_df;
`endif

    assign is_mul = (op[4:1] == 4'b0001);
`ifdef ALU_MC_DIVIDER_EN
    assign is_div = (op == 5'b00110) || (op == 5'b00100);
    assign multi  = is_mul | is_div;
    assign sgn    = is_mul ? ~op[0] : op[1];
`else
    assign multi  = is_mul;
    assign sgn    = ~op[0];
`endif
    assign mag_a   = (sgn && a[WIDTH-1]) ? -a : a;
    assign mag_b   = (sgn && b[WIDTH-1]) ? -b : b;
    assign cnt_nxt = cnt + CW'(1);
    assign tt      = op[3:0];

    // Single-cycle datapath, evaluated directly on the launch operands
    always_comb begin
        s_y     = '0;
        s_v     = 1'b0;
        s_err   = 1'b0;
        s_hi_we = 1'b0;
        add_r   = a + b;
        sub_r   = a - b;
        if (op[4]) begin
            for (int i = 0; i < WIDTH; i++) s_y[i] = tt[{a[i], b[i]}];
        end else begin
            case (op[3:0])
                4'b0001: begin
                    s_y = sub_r;
                    s_v = (a[WIDTH-1] != b[WIDTH-1]) && (sub_r[WIDTH-1] != a[WIDTH-1]);
                end
                4'b0101: s_y = {{(WIDTH-1){1'b0}}, $signed(a) <  $signed(b)};
                4'b0111: s_y = {{(WIDTH-1){1'b0}}, a < b};
                4'b1101: s_y = {{(WIDTH-1){1'b0}}, $signed(a) <= $signed(b)};
                4'b1000: s_y = a << b[SHW-1:0];
                4'b1001: s_y = a >> b[SHW-1:0];
                4'b1011: s_y = $signed(a) >>> b[SHW-1:0];
`ifndef ALU_MC_DIVIDER_EN
                4'b0100, 4'b0110: begin
                    s_hi_we = 1'b1;
                    s_err   = 1'b1;
                end
`endif
                default: begin
                    s_y = add_r;
                    s_v = (a[WIDTH-1] == b[WIDTH-1]) && (add_r[WIDTH-1] != a[WIDTH-1]);
                end
            endcase
        end
    end

    // One iteration step plus the sign/exception fix-up applied on the final step
    always_comb begin
        m_sum = {1'b0, wk_hi} + (wk_lo[0] ? {1'b0, mag} : '0);
        nx_hi = m_sum[WIDTH:1];
        nx_lo = {m_sum[0], wk_lo[WIDTH-1:1]};
        prod  = {nx_hi, nx_lo};
        if (neg_q) prod = -prod;
        f_y   = prod[WIDTH-1:0];
        f_hi  = prod[2*WIDTH-1:WIDTH];
        f_v   = 1'b0;
        f_err = 1'b0;
`ifdef ALU_MC_DIVIDER_EN
        d_rs = {wk_hi, wk_lo[WIDTH-1]};
        d_df = d_rs - {1'b0, mag};
        if (mode_div) begin
            nx_hi = d_df[WIDTH] ? d_rs[WIDTH-1:0] : d_df[WIDTH-1:0];
            nx_lo = {wk_lo[WIDTH-2:0], ~d_df[WIDTH]};
            if (b_zero) begin
                f_y   = '1;
                f_hi  = a_r;
                f_err = 1'b1;
            end else begin
                f_y  = neg_q ? -nx_lo : nx_lo;
                f_hi = neg_r ? -nx_hi : nx_hi;
                f_v  = ovf;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st    <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            y     <= '0;
            hi    <= '0;
            z     <= 1'b0;
            v     <= 1'b0;
            n     <= 1'b0;
            err   <= 1'b0;
            cnt   <= '0;
            wk_hi <= '0;
            wk_lo <= '0;
            mag   <= '0;
            neg_q <= 1'b0;
`ifdef ALU_MC_DIVIDER_EN
            mode_div <= 1'b0;
            a_r      <= '0;
            b_zero   <= 1'b0;
            ovf      <= 1'b0;
            neg_r    <= 1'b0;
`endif
        end else begin
            case (st)
                IDLE, DONE: begin
                    done <= 1'b0;
                    st   <= IDLE;
                    if (start) begin
                        if (multi) begin
                            st    <= RUN;
                            busy  <= 1'b1;
                            cnt   <= '0;
                            neg_q <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                            wk_hi <= '0;
                            wk_lo <= mag_b;
                            mag   <= mag_a;
`ifdef ALU_MC_DIVIDER_EN
                            mode_div <= is_div;
                            a_r      <= a;
                            b_zero   <= (b == '0);
                            ovf      <= sgn && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
                            neg_r    <= sgn & a[WIDTH-1];
                            if (is_div) begin
                                wk_lo <= mag_a;
                                mag   <= mag_b;
                            end
`endif
                        end else begin
                            st   <= DONE;
                            done <= 1'b1;
                            y    <= s_y;
                            z    <= (s_y == '0);
                            n    <= s_y[WIDTH-1];
                            v    <= s_v;
                            err  <= s_err;
                            if (s_hi_we) hi <= '0;
                        end
                    end
                end
                RUN: begin
                    wk_hi <= nx_hi;
                    wk_lo <= nx_lo;
                    cnt   <= cnt_nxt;
                    if (cnt_nxt == CW'(WIDTH)) begin
                        st   <= DONE;
                        busy <= 1'b0;
                        done <= 1'b1;
                        y    <= f_y;
                        hi   <= f_hi;
                        z    <= (f_y == '0);
                        n    <= f_y[WIDTH-1];
                        v    <= f_v;
                        err  <= f_err;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: driver pushes model results, negedge monitor pops on done.
module tb_alu_mc;
    localparam int W = 32;

    logic          clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [4:0]    op = '0;
    logic [W-1:0]  a = '0, b = '0;
    logic          busy, done, z, v, n, err;
    logic [W-1:0]  y, hi;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .y(y), .hi(hi), .z(z), .v(v), .n(n), .err(err)
    );

    typedef struct {
        logic [31:0] y;
        logic [31:0] hi;
        logic        z, v, n, err;
        int          lat;
        time         t;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          errors = 0, checks = 0, ndone = 0, busy_cnt = 0;
    logic [31:0] m_hi = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference: plain integer arithmetic on 64-bit values
    function automatic exp_t model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] w);
        exp_t        e;
        longint      sx, sw, res, sr;
        logic [63:0] wide;
        logic [31:0] r;
        sx = $signed(x);
        sw = $signed(w);
        e.v = 1'b0; e.err = 1'b0; e.lat = 1; e.t = 0; r = '0;
        if (o[4]) begin
            r = (o[3] ? (x & w) : 32'h0) | (o[2] ? (x & ~w) : 32'h0) |
                (o[1] ? (~x & w) : 32'h0) | (o[0] ? (~x & ~w) : 32'h0);
        end else begin
            case (o)
                5'b00001: begin res = sx - sw; r = x - w; sr = $signed(r); e.v = (res != sr); end
                5'b00101: r = {31'b0, sx < sw};
                5'b00111: r = {31'b0, x < w};
                5'b01101: r = {31'b0, sx <= sw};
                5'b01000: r = x << w[4:0];
                5'b01001: r = x >> w[4:0];
                5'b01011: r = $signed(x) >>> w[4:0];
                5'b00010: begin wide = sx * sw; r = wide[31:0]; m_hi = wide[63:32]; e.lat = W + 1; end
                5'b00011: begin wide = {32'b0, x} * {32'b0, w}; r = wide[31:0]; m_hi = wide[63:32]; e.lat = W + 1; end
                5'b00110, 5'b00100: begin
`ifdef ALU_MC_DIVIDER_EN
                    e.lat = W + 1;
                    if (w == 0) begin
                        r = '1; m_hi = x; e.err = 1'b1;
                    end else if (o == 5'b00110) begin
                        res = sx / sw; r = res[31:0];
                        wide = sx % sw; m_hi = wide[31:0];
                        e.v = (res == 64'sd2147483648);
                    end else begin
                        r = x / w; m_hi = x % w;
                    end
`else
                    r = '0; m_hi = '0; e.err = 1'b1;
`endif
                end
                default: begin res = sx + sw; r = x + w; sr = $signed(r); e.v = (res != sr); end
            endcase
        end
        e.y = r; e.hi = m_hi; e.z = (r == 0); e.n = r[31];
        return e;
    endfunction

    task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] w);
        exp_t e;
        @(negedge clk);
        op = o; a = x; b = w; start = 1'b1;
        e = model(o, x, w);
        e.t = $time + 10 * e.lat;
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sbq.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (sbq.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d results still pending", sbq.size());
            sbq.delete();
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) if (busy) busy_cnt++;

    always @(negedge clk) begin
        if (!reset && done) begin
            ndone++;
            if (sbq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: y=%h hi=%h", y, hi);
            end else begin
                mon_e = sbq.pop_front();
                chk("y", 64'(y), 64'(mon_e.y));
                chk("hi", 64'(hi), 64'(mon_e.hi));
                chk("flags_zvne", 64'({z, v, n, err}), 64'({mon_e.z, mon_e.v, mon_e.n, mon_e.err}));
                chk("done_time", 64'($time), 64'(mon_e.t));
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] ops [13];
        exp_t       e2;
        int         b0, d0, k;
        logic [4:0] ro;
        ops = '{5'd0, 5'd1, 5'd5, 5'd7, 5'd13, 5'd8, 5'd9, 5'd11, 5'd2, 5'd3, 5'd6, 5'd4, 5'd16};

        repeat (2) @(negedge clk);
        chk("reset_outputs", 64'({y, busy, done, z, v, n, err}), 64'h0);
        chk("reset_hi", 64'(hi), 64'h0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_outputs", 64'({y, hi, busy, done, z, v, n, err}), 64'h0);

        issue(5'b00000, 32'h7FFFFFFF, 32'h1);        drain();
        issue(5'b00001, 32'd5, 32'd5);               drain();
        b0 = busy_cnt;
        issue(5'b00010, 32'hFFFFFFFE, 32'd3);        drain();
        chk("mult_busy_cycles", 64'(busy_cnt - b0), 64'd32);
        issue(5'b00011, 32'hFFFFFFFE, 32'd3);        drain();

        // Abort a multiply part-way through
        @(negedge clk);
        op = 5'b00010; a = 32'h12345; b = 32'h777; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("busy_mid_mult", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_outputs", 64'({busy, done, y, hi}), 64'h0);
        reset = 1'b0;
        m_hi = '0;

        issue(5'b00110, 32'hFFFFFFF9, 32'd2);        drain();
        issue(5'b00100, 32'd9, 32'd0);               drain();
        issue(5'b00110, 32'h80000000, 32'hFFFFFFFF); drain();
        issue(5'b00110, 32'd7, 32'hFFFFFFFE);        drain();
        issue(5'b11000, 32'h0000F0F0, 32'h0000FF00); drain();
        issue(5'b01011, 32'h80000000, 32'd24);       drain();
        issue(5'b00111, 32'd1, 32'hFFFFFFFF);        drain();
        issue(5'b00101, 32'd1, 32'hFFFFFFFF);        drain();
        issue(5'b01101, 32'd4, 32'd4);               drain();
        issue(5'b10110, 32'hA5A5A5A5, 32'h0FF00FF0); drain();

        // start held through a DIVU; the follow-on ADD is taken in the DONE cycle
        d0 = ndone; b0 = busy_cnt;
        @(negedge clk);
        op = 5'b00100; a = 32'd100; b = 32'd7; start = 1'b1;
        e2 = model(5'b00100, 32'd100, 32'd7);
        e2.t = $time + 10 * e2.lat;
        sbq.push_back(e2);
        @(negedge clk);
        op = 5'b00000; a = 32'd40; b = 32'd2;
        k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL b2b_timeout: no done for held DIVU");
        end
        e2 = model(5'b00000, 32'd40, 32'd2);
        e2.t = $time + 10;
        sbq.push_back(e2);
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        chk("b2b_done_pulses", 64'(ndone - d0), 64'd2);
`ifdef ALU_MC_DIVIDER_EN
        chk("b2b_busy_cycles", 64'(busy_cnt - b0), 64'd32);
`else
        chk("b2b_busy_cycles", 64'(busy_cnt - b0), 64'd0);
`endif

        for (int i = 0; i < 60; i++) begin
            ro = ops[$urandom_range(0, 12)];
            if (ro == 5'd16) ro = 5'(16 + $urandom_range(0, 15));
            issue(ro, pick(), pick());
            drain();
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
